// File: rtl/seg_pkg.sv
// seg_scan_mux shared definitions: hex font table and decode helper.
// Segment bit order is {dp, g, f, e, d, c, b, a}, active-high.
package seg_pkg;

  localparam logic [6:0] SEG_FONT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h27,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

  localparam logic [7:0] SEG_OFF = 8'h00;

  function automatic logic [6:0] hex_to_seg(
    input logic [3:0] nibble
  );
    return SEG_FONT[nibble];
  endfunction

endpackage

// File: rtl/seg_scan_mux_decode.sv
// seg_hex_decode: combinational nibble to 7-segment pattern.
// Output is active-high, with bit0 = segment a.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  assign o_seg = hex_to_seg(i_nibble);

endmodule

// File: rtl/seg_scan_mux.sv
// seg_scan_mux: self-timed multi-digit 7-segment scanner with
// frame-aligned shadow data, lz suppression and blanking window.
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYC    = 2,
  parameter int COMMON_ANODE = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    wr_en,
  input  logic [4*NUM_DIGITS-1:0] wdata,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    lz_sup,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int DW    = 4 * NUM_DIGITS;
  localparam bit INV   = (COMMON_ANODE != 0);

  localparam logic [7:0]            SEG_IDLE = SEG_OFF ^ {8{INV}};
  localparam logic [NUM_DIGITS-1:0] AN_IDLE  = {NUM_DIGITS{INV}};

  logic [CNT_W-1:0]      r_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic [DW-1:0]         r_disp_data;
  logic [NUM_DIGITS-1:0] r_disp_dp;
  logic [DW-1:0]         r_pend_data;
  logic [NUM_DIGITS-1:0] r_pend_dp;
  logic                  r_pend_valid;

  logic                  w_last;
  logic                  w_wrap;
  logic                  w_in_blank;
  logic                  w_show;
  logic [3:0]            w_nib;
  logic                  w_dp;
  logic                  w_lz_blank;
  logic                  w_zero_run;
  logic [NUM_DIGITS-1:0] w_an_hot;
  logic [6:0]            w_font;
  logic [7:0]            w_seg_nxt;
  logic [NUM_DIGITS-1:0] w_an_nxt;

  assign w_last = (r_cnt == CNT_W'(REFRESH_DIV - 1));
  assign w_wrap = en && w_last &&
                  (r_idx == IDX_W'(NUM_DIGITS - 1));

  generate
    if (BLANK_CYC == 0) begin : g_no_blank
      assign w_in_blank = 1'b0;
    end else begin : g_blank
      assign w_in_blank = (r_cnt < CNT_W'(BLANK_CYC));
    end
  endgenerate

  assign w_show = en && !w_in_blank;

  // Zero-run scans from the top digit down to the selected one.
  always_comb begin
    w_nib      = 4'h0;
    w_dp       = 1'b0;
    w_lz_blank = 1'b0;
    w_an_hot   = '0;
    w_zero_run = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      w_zero_run = w_zero_run && (r_disp_data[k*4 +: 4] == 4'h0);
      if (k == int'(r_idx)) begin
        w_nib       = r_disp_data[k*4 +: 4];
        w_dp        = r_disp_dp[k];
        w_an_hot[k] = 1'b1;
        w_lz_blank  = lz_sup && (k != 0) && w_zero_run;
      end
    end
  end

  seg_hex_decode u_dec (
    .i_nibble (w_nib),
    .o_seg    (w_font)
  );

  always_comb begin
    w_seg_nxt = {w_dp, w_font};
    w_an_nxt  = w_an_hot;
    if (w_lz_blank) begin
      w_seg_nxt = SEG_OFF;
    end
    if (!w_show) begin
      w_seg_nxt = SEG_OFF;
      w_an_nxt  = '0;
    end
    w_seg_nxt = w_seg_nxt ^ {8{INV}};
    w_an_nxt  = w_an_nxt ^ {NUM_DIGITS{INV}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_idx        <= '0;
      r_disp_data  <= '0;
      r_disp_dp    <= '0;
      r_pend_data  <= '0;
      r_pend_dp    <= '0;
      r_pend_valid <= 1'b0;
      frame_tick   <= 1'b0;
      seg          <= SEG_IDLE;
      an           <= AN_IDLE;
    end else begin
      if (en) begin
        if (w_last) begin
          r_cnt <= '0;
          r_idx <= w_wrap ? '0 : r_idx + IDX_W'(1);
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
      frame_tick <= w_wrap;
      // A write landing on the boundary bypasses pending.
      if (w_wrap) begin
        r_pend_valid <= 1'b0;
        if (wr_en) begin
          r_disp_data <= wdata;
          r_disp_dp   <= dp_in;
        end else if (r_pend_valid) begin
          r_disp_data <= r_pend_data;
          r_disp_dp   <= r_pend_dp;
        end
      end else if (wr_en) begin
        r_pend_data  <= wdata;
        r_pend_dp    <= dp_in;
        r_pend_valid <= 1'b1;
      end
      seg <= w_seg_nxt;
      an  <= w_an_nxt;
    end
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux: scan timing, shadow commit,
// boundary write, lz suppression, enable hold, async reset, polarity.
module tb_seg_scan_mux;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        wr_en;
  logic [15:0] wdata;
  logic [3:0]  dp_in;
  logic        lz_sup;
  logic [7:0]  seg_a;
  logic [3:0]  an_a;
  logic        ft_a;
  logic [7:0]  seg_b;
  logic [3:0]  an_b;
  logic        ft_b;

  int checks = 0;
  int errors = 0;

  seg_scan_mux #(
    .NUM_DIGITS   (4),
    .REFRESH_DIV  (8),
    .BLANK_CYC    (2),
    .COMMON_ANODE (0)
  ) dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .wr_en      (wr_en),
    .wdata      (wdata),
    .dp_in      (dp_in),
    .lz_sup     (lz_sup),
    .seg        (seg_a),
    .an         (an_a),
    .frame_tick (ft_a)
  );

  seg_scan_mux #(
    .NUM_DIGITS   (4),
    .REFRESH_DIV  (8),
    .BLANK_CYC    (2),
    .COMMON_ANODE (1)
  ) dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .wr_en      (wr_en),
    .wdata      (wdata),
    .dp_in      (dp_in),
    .lz_sup     (lz_sup),
    .seg        (seg_b),
    .an         (an_b),
    .frame_tick (ft_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string      tag,
    input logic [7:0] obs,
    input logic [7:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(
    input string      tag,
    input logic [3:0] ea,
    input logic [7:0] es,
    input logic       et
  );
    chk({tag, "_an"},     {4'h0, an_a}, {4'h0, ea});
    chk({tag, "_seg"},    seg_a,        es);
    chk({tag, "_tick"},   {7'h0, ft_a}, {7'h0, et});
    chk({tag, "_an_ca"},  {4'h0, an_b}, {4'h0, ~ea});
    chk({tag, "_seg_ca"}, seg_b,        ~es);
    chk({tag, "_tick_ca"},{7'h0, ft_b}, {7'h0, et});
  endtask

  // Called on a frame_tick sample; checks the following 32 cycles.
  // ex = {seg d3, seg d2, seg d1, seg d0}.
  task automatic check_frame(
    input string       tag,
    input logic [31:0] ex,
    input int          wa,
    input logic [15:0] da,
    input logic [3:0]  pa,
    input int          wb,
    input logic [15:0] db,
    input logic [3:0]  pb
  );
    int c;
    int d;
    logic [3:0] ea;
    logic [7:0] es;
    for (int j = 1; j <= 32; j++) begin
      @(negedge clk);
      c = (j - 1) % 8;
      d = (j - 1) / 8;
      if (c >= 2) begin
        ea = 4'b0001 << d;
        es = ex[d*8 +: 8];
      end else begin
        ea = 4'b0000;
        es = 8'h00;
      end
      chk_out(tag, ea, es, (j == 32));
      wr_en = 1'b0;
      if (j == wa) begin
        wr_en = 1'b1;
        wdata = da;
        dp_in = pa;
      end
      if (j == wb) begin
        wr_en = 1'b1;
        wdata = db;
        dp_in = pb;
      end
    end
  endtask

  initial begin
    logic       found;
    logic [3:0] ea;
    logic [7:0] es;
    rst_n  = 1'b0;
    en     = 1'b0;
    wr_en  = 1'b0;
    wdata  = 16'h0000;
    dp_in  = 4'h0;
    lz_sup = 1'b0;

    @(negedge clk);
    @(negedge clk);
    chk_out("reset", 4'h0, 8'h00, 1'b0);

    rst_n = 1'b1;
    en    = 1'b1;
    wr_en = 1'b1;
    wdata = 16'h1234;
    dp_in = 4'h0;
    @(negedge clk);
    wr_en = 1'b0;

    found = 1'b0;
    for (int i = 0; i < 80 && !found; i++) begin
      @(negedge clk);
      if (ft_a) found = 1'b1;
    end
    chk("first_tick", {7'h0, found}, 8'h01);

    check_frame("f1234", 32'h065B4F66,
                10, 16'hABCD, 4'h0, 20, 16'hEF01, 4'h0);
    check_frame("fEF01", 32'h79713F06,
                10, 16'h5555, 4'h0, 31, 16'h0F00, 4'h0);
    check_frame("f0F00", 32'h3F713F3F,
                10, 16'h0050, 4'b1000, -1, 16'h0, 4'h0);
    lz_sup = 1'b1;
    check_frame("lz0050", 32'h00006D3F,
                10, 16'h0000, 4'h0, -1, 16'h0, 4'h0);
    check_frame("lz0000", 32'h0000003F,
                10, 16'h0050, 4'b1010, -1, 16'h0, 4'h0);
    lz_sup = 1'b0;
    check_frame("dp0050", 32'hBF3FED3F,
                -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

    // Advance to cnt=5, idx=2 and disable.
    repeat (21) @(negedge clk);
    en = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk_out("hold", 4'h0, 8'h00, 1'b0);
    end
    en = 1'b1;
    for (int m = 1; m <= 11; m++) begin
      @(negedge clk);
      if (m <= 3) begin
        ea = 4'b0100;
        es = 8'h3F;
      end else if (m <= 5) begin
        ea = 4'b0000;
        es = 8'h00;
      end else begin
        ea = 4'b1000;
        es = 8'hBF;
      end
      chk_out("resume", ea, es, (m == 11));
    end

    // Reset lands while tick and a digit are both active.
    rst_n = 1'b0;
    #1;
    chk_out("async_rst", 4'h0, 8'h00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_out("post_rst_blank", 4'h0, 8'h00, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk_out("post_rst_d0", 4'b0001, 8'h3F, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
